// File: rtl/npu_vec_pkg.sv
// Shared types and constants for the vector unit: geometry of a vector
// register, element type and the store-streamer state encoding.
package npu_vec_pkg;

  localparam int WIDTH       = 16;
  localparam int NUM_ELEMS   = 16;
  localparam int VEC_W       = WIDTH * NUM_ELEMS;
  localparam int NUM_VREGS   = 4;
  localparam int VREG_ADDR_W = 2;

  typedef logic [VEC_W-1:0] vec_t;
  typedef logic [WIDTH-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } vss_state_t;

  // Requested element counts above a full vector are treated as a full vector.
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    logic [4:0] max_len;
    max_len = 5'(NUM_ELEMS);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/vector_store_streamer.sv
// Unloads one vector register: snapshots it through the register-file read
// port in a single FETCH cycle, then streams the first len elements over a
// valid/ready channel with an incrementing element address. All outputs are
// driven from registers; the next-state process computes their next values.
module vector_store_streamer #(
  parameter int WIDTH     = 16,
  parameter int NUM_ELEMS = 16,
  parameter int ADDR_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 start_reg,
  input  logic [4:0]                 start_len,
  input  logic [ADDR_W-1:0]          start_base_addr,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 rf_read_addr,
  input  logic [WIDTH*NUM_ELEMS-1:0] rf_read_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       out_last
);

  import npu_vec_pkg::*;

  localparam int SH_W  = WIDTH * NUM_ELEMS;
  localparam int IDX_W = $clog2(NUM_ELEMS);

  vss_state_t          state_r,     state_s;
  logic [4:0]          len_r,       len_s;
  logic [ADDR_W-1:0]   base_r,      base_s;
  logic [4:0]          idx_r,       idx_s;
  logic [SH_W-1:0]     shadow_r,    shadow_s;
  logic                busy_r,      busy_s;
  logic                done_r,      done_s;
  logic [1:0]          rf_addr_r,   rf_addr_s;
  logic                out_valid_r, out_valid_s;
  logic [WIDTH-1:0]    out_data_r,  out_data_s;
  logic [ADDR_W-1:0]   out_addr_r,  out_addr_s;
  logic                out_last_r,  out_last_s;
  logic [4:0]          idx_nxt_s;
  logic [4:0]          len_clamp_s;

  // Next-state and next-output computation for the unload sequencer.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    base_s      = base_r;
    idx_s       = idx_r;
    shadow_s    = shadow_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    rf_addr_s   = rf_addr_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    out_addr_s  = out_addr_r;
    out_last_s  = out_last_r;
    idx_nxt_s   = idx_r + 5'd1;
    len_clamp_s = clamp_len(start_len);

    case (state_r)
      IDLE: begin
        if (start) begin
          len_s  = len_clamp_s;
          base_s = start_base_addr;
          idx_s  = 5'd0;
          if (len_clamp_s == 5'd0) begin
            // Nothing to unload: skip the register-file read entirely.
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s   = FETCH;
            busy_s    = 1'b1;
            rf_addr_s = start_reg;
          end
        end else begin
          state_s = IDLE;
        end
      end

      FETCH: begin
        // Snapshot taken here; later register-file writes are not seen.
        shadow_s    = rf_read_data;
        state_s     = STREAM;
        rf_addr_s   = 2'd0;
        out_valid_s = 1'b1;
        out_data_s  = rf_read_data[WIDTH-1:0];
        out_addr_s  = base_r;
        out_last_s  = (len_r == 5'd1);
      end

      STREAM: begin
        if (out_valid_r && out_ready) begin
          if (out_last_r) begin
            state_s     = DONE;
            busy_s      = 1'b0;
            done_s      = 1'b1;
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
            out_data_s  = '0;
            out_addr_s  = '0;
          end else begin
            idx_s      = idx_nxt_s;
            out_data_s = shadow_r[idx_nxt_s[IDX_W-1:0]*WIDTH +: WIDTH];
            out_addr_s = base_r + ADDR_W'(idx_nxt_s);
            out_last_s = (idx_nxt_s == (len_r - 5'd1));
          end
        end else begin
          // Stalled: every output holds its current value.
          state_s = STREAM;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s     = IDLE;
        busy_s      = 1'b0;
        rf_addr_s   = 2'd0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        out_data_s  = '0;
        out_addr_s  = '0;
      end
    endcase
  end

  // State, shadow copy and registered outputs; reset abandons any stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      len_r       <= 5'd0;
      base_r      <= '0;
      idx_r       <= 5'd0;
      shadow_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rf_addr_r   <= 2'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_addr_r  <= '0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      base_r      <= base_s;
      idx_r       <= idx_s;
      shadow_r    <= shadow_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      rf_addr_r   <= rf_addr_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_addr_r  <= out_addr_s;
      out_last_r  <= out_last_s;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign rf_read_addr = rf_addr_r;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_addr     = out_addr_r;
  assign out_last     = out_last_r;

endmodule

// File: tb/tb_vector_store_streamer.sv
// Directed bench for vector_store_streamer with a behavioural register file
// and a scoreboard of expected {data, addr, last} beats.
module tb_vector_store_streamer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   start_reg;
  logic [4:0]   start_len;
  logic [15:0]  start_base_addr;
  logic         busy;
  logic         done;
  logic [1:0]   rf_read_addr;
  logic [255:0] rf_read_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [15:0]  out_addr;
  logic         out_last;

  logic [255:0] regs [4];
  logic [32:0]  exp_q [$];
  int errors = 0;
  int checks = 0;

  assign rf_read_data = regs[rf_read_addr];

  always #5 clk = ~clk;

  vector_store_streamer #(.WIDTH(16), .NUM_ELEMS(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_reg(start_reg),
    .start_len(start_len), .start_base_addr(start_base_addr),
    .busy(busy), .done(done), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: ready high with a
  // second start held during the stream and a write to reg0 element 1 after FETCH.
  task automatic run_stream(input logic [1:0] r, input logic [4:0] len, input logic [15:0] base,
                            input int mode, output int ntx, output int done_cyc);
    int l;
    logic [255:0] v;
    logic [32:0] got;
    logic [32:0] e;
    logic [32:0] held;
    logic held_valid;
    l = (len > 5'd16) ? 16 : int'(len);
    v = regs[r];
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({v[i*16 +: 16], 16'(base + 16'(i)), (i == l - 1)});
    end
    ntx = 0;
    done_cyc = -1;
    held_valid = 1'b0;
    held = '0;
    @(negedge clk);
    start = 1'b1; start_reg = r; start_len = len; start_base_addr = base; out_ready = 1'b0;
    @(negedge clk);
    if (mode == 2) begin
      start_reg = 2'd1; start_len = 5'd2; start_base_addr = 16'h5555;
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k < 200; k++) begin
      if (mode == 2 && k == 1) regs[0][31:16] = 16'hF00D;
      if (mode == 2 && k == 3) start = 1'b0;
      if (done) begin
        done_cyc = k;
        check("busy_at_done", 64'(busy), 64'd0);
        check("valid_at_done", 64'(out_valid), 64'd0);
        check("rf_addr_at_done", 64'(rf_read_addr), 64'd0);
        break;
      end
      check("busy", 64'(busy), 64'd1);
      check("rf_addr", 64'(rf_read_addr), (k == 0) ? 64'(r) : 64'd0);
      if (k == 0) check("valid_in_fetch", 64'(out_valid), 64'd0);
      if (held_valid) begin
        check("valid_hold", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({out_data, out_addr, out_last}), 64'(held));
      end
      out_ready = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      held_valid = 1'b0;
      if (out_valid) begin
        got = {out_data, out_addr, out_last};
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_elem", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("elem", 64'(got), 64'(e));
          end
          ntx++;
        end else begin
          held_valid = 1'b1;
          held = got;
        end
      end
      @(negedge clk);
    end
    if (done_cyc < 0) begin
      check("done_timeout", 64'(done), 64'd1);
    end else begin
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int dc;
    rst_n = 1'b0; start = 1'b0; start_reg = 2'd0; start_len = 5'd0;
    start_base_addr = 16'h0; out_ready = 1'b0;
    regs[0] = {4{64'h123456789ABCDEF0}};
    for (int j = 1; j < 4; j++) begin
      for (int w = 0; w < 8; w++) regs[j][w*32 +: 32] = $urandom;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_outs", 64'({out_data, out_addr, out_last, rf_read_addr}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic stream, ready held high
    run_stream(2'd0, 5'd4, 16'h0100, 0, n, dc);
    check("t1_ntx", 64'(n), 64'd4);
    check("t1_done_cycle", 64'(dc), 64'd5);

    // 2: same stream with stalls
    run_stream(2'd0, 5'd4, 16'h0100, 1, n, dc);
    check("t2_ntx", 64'(n), 64'd4);

    // 3: zero length, then over-long length clamped to a full vector
    run_stream(2'd1, 5'd0, 16'h0300, 0, n, dc);
    check("t3_len0_ntx", 64'(n), 64'd0);
    check("t3_len0_done_cycle", 64'(dc), 64'd0);
    run_stream(2'd2, 5'd31, 16'h0400, 0, n, dc);
    check("t3_len31_ntx", 64'(n), 64'd16);
    check("t3_len31_done_cycle", 64'(dc), 64'd17);

    // 4: address wrap
    run_stream(2'd3, 5'd4, 16'hFFFE, 0, n, dc);
    check("t4_ntx", 64'(n), 64'd4);

    // 5: start while busy plus register write after the snapshot
    run_stream(2'd0, 5'd4, 16'h0100, 2, n, dc);
    check("t5_ntx", 64'(n), 64'd4);
    check("t5_done_cycle", 64'(dc), 64'd5);

    // 6: reset in the middle of a stream, then a clean restart
    regs[0] = {4{64'h123456789ABCDEF0}};
    @(negedge clk);
    start = 1'b1; start_reg = 2'd0; start_len = 5'd4; start_base_addr = 16'h0200; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t6_valid_before", 64'(out_valid), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("t6_elem2", 64'({out_data, out_addr}), 64'({16'h5678, 16'h0202}));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_last", 64'(out_last), 64'd0);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_stream(2'd0, 5'd4, 16'h0200, 0, n, dc);
    check("t6_restart_ntx", 64'(n), 64'd4);
    check("t6_restart_done_cycle", 64'(dc), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_store_streamer.md
Name: vector_store_streamer

Overview:
Read-side counterpart of vector_regs. It takes a start command naming one of the 4 vector registers and fetches that 256-bit register through the vector_regs read port into a local shadow copy. It then streams the first start_len 16-bit elements out over a valid/ready interface, each tagged with an incrementing element address. It sits between the vector register file and the store path to memory or the host.

Parameters:
WIDTH, 16, element width in bits
NUM_ELEMS, 16, elements per vector (VEC_W = WIDTH*NUM_ELEMS = 256)
ADDR_W, 16, width of output element address

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  command strobe, accepted only in IDLE
start_reg  in  2  vector register index to unload
start_len  in  5  element count 0..16; values >16 clamp to 16
start_base_addr  in  ADDR_W  address of element 0
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle completion pulse
rf_read_addr  out  2  to vector_regs read_addr
rf_read_data  in  256  from vector_regs read_data (combinational read)
out_valid  out  1  element available
out_ready  in  1  downstream accepts
out_data  out  WIDTH  current element
out_addr  out  ADDR_W  address of current element
out_last  out  1  current element is the final one

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, out_valid, out_last=0; out_data, out_addr, rf_read_addr=0; shadow and counters cleared. Effect is immediate mid-stream; no done pulse; the stream is abandoned.
- States: IDLE, FETCH, STREAM, DONE.
- IDLE: on start=1, latch reg, len (clamped) and base.
  - If len=0, go to DONE (no register-file read).
  - Otherwise go to FETCH with idx=0.
- FETCH (exactly 1 cycle): rf_read_addr=latched reg. At the closing edge, shadow<=rf_read_data. Go to STREAM.
- STREAM:
  - out_valid=1.
  - out_data=shadow[idx*WIDTH +: WIDTH]; element 0 = bits [15:0].
  - out_addr=base+idx, modulo 2^ADDR_W (wraps silently).
  - out_last=(idx==len-1).
- Handshake: a transfer happens when out_valid&&out_ready at a rising edge.
  - out_data, out_addr and out_last hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops before its transfer.
  - On transfer: idx++. If out_last, go to DONE.
  - Back-to-back transfers are allowed (1 element/cycle with out_ready held high).
- DONE (1 cycle): done=1, busy=0. Go to IDLE. A start in this cycle is ignored.
- busy=1 in FETCH and STREAM.
- start while not IDLE is ignored, with no effect on the stream in progress.
- rf_read_addr is 0 outside FETCH.
- Latency, start accepted at edge E0:
  - FETCH during cycle E0..E1.
  - First out_valid during E1..E2.
  - With out_ready held high, done is high during cycle E(len+1)..E(len+2).
- Snapshot semantics: writes to vector_regs after the FETCH edge do not affect streamed data.

Decomposition:
- Shared package npu_vec_pkg holds:
  - localparams WIDTH, NUM_ELEMS, VEC_W, NUM_VREGS=4, VREG_ADDR_W=2;
  - typedef vec_t (logic [VEC_W-1:0]) and elem_t (logic [WIDTH-1:0]);
  - enum vss_state_t {IDLE, FETCH, STREAM, DONE}.
- No sub-module required. The element select is an indexed part-select inside the block.

Test Plan:
1. Preload reg0 via full_we=256'h123456789ABCDEF0 (repeated x4); start reg=0, len=4, base=16'h0100, out_ready=1 -> out_data DEF0,9ABC,5678,1234 on consecutive cycles; out_addr 0100..0103; out_last only on the 4th; done pulses 1 cycle later; busy deasserts with done.
2. Same stream with out_ready toggling 1,0,0,1,... -> data/addr/last held stable while stalled; no element lost or duplicated; exactly 4 transfers.
3. len=0 -> no out_valid ever; rf_read_addr stays 0; done pulses in the cycle after start. len=31 -> clamped to 16, exactly 16 transfers, last on idx 15.
4. base=16'hFFFE, len=4 -> out_addr FFFE,FFFF,0000,0001.
5. Start while busy, and partial write F00D to reg0 element 1 after FETCH -> second start ignored; streamed element 1 remains 9ABC.
6. Assert rst_n=0 mid-stream after 2 transfers -> out_valid, busy and done go 0 immediately; no done pulse; after release a new start streams correctly from element 0.
